// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the
// 5-bit opcode encoding used by the execute stage.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'h00,
    ALU_ADD  = 5'h01,
    ALU_SUB  = 5'h02,
    ALU_MULU = 5'h03,
    ALU_DIVU = 5'h04,
    ALU_MODU = 5'h05,
    ALU_SHL  = 5'h06,
    ALU_SHR  = 5'h07,
    ALU_ROL  = 5'h08,
    ALU_ROR  = 5'h09,
    ALU_AND  = 5'h0A,
    ALU_OR   = 5'h0B,
    ALU_XOR  = 5'h0C,
    ALU_NOR  = 5'h0D,
    ALU_NAND = 5'h0E,
    ALU_XNOR = 5'h0F,
    ALU_GTU  = 5'h10,
    ALU_EQ   = 5'h11,
    ALU_MULS = 5'h12,
    ALU_SRA  = 5'h13
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes the opcode
// and produces the full double-width result.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [4:0]     op,
  output logic [2*W-1:0] y
);

  localparam int SW = $clog2(W);

  logic [SW-1:0]  sh;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod_u;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] dbl_l;
  logic [2*W-1:0] dbl_r;
  logic [W-1:0]   sra_v;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [2*W-1:0] a_sx;
  logic [2*W-1:0] b_sx;

  assign sh = b[SW-1:0];

  // Shared arithmetic terms feeding the result mux
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    a_sx   = {{W{a[W-1]}}, a};
    b_sx   = {{W{b[W-1]}}, b};
    prod_s = a_sx * b_sx;
    dbl_l  = {a, a} << sh;
    dbl_r  = {a, a} >> sh;
    sra_v  = W'($signed(a) >>> sh);
    quo    = (b == '0) ? '1 : a / b;
    rem    = (b == '0) ? a : a % b;
  end

  // Opcode decode selecting the zero-extended result
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = {{(W-1){1'b0}}, sum};
      ALU_SUB:  y = {{(W-1){1'b0}}, diff};
      ALU_MULU: y = prod_u;
      ALU_DIVU: y = {{W{1'b0}}, quo};
      ALU_MODU: y = {{W{1'b0}}, rem};
      ALU_SHL:  y = {{W{1'b0}}, a << sh};
      ALU_SHR:  y = {{W{1'b0}}, a >> sh};
      ALU_ROL:  y = {{W{1'b0}}, dbl_l[2*W-1:W]};
      ALU_ROR:  y = {{W{1'b0}}, dbl_r[W-1:0]};
      ALU_AND:  y = {{W{1'b0}}, a & b};
      ALU_OR:   y = {{W{1'b0}}, a | b};
      ALU_XOR:  y = {{W{1'b0}}, a ^ b};
      ALU_NOR:  y = {{W{1'b0}}, ~(a | b)};
      ALU_NAND: y = {{W{1'b0}}, ~(a & b)};
      ALU_XNOR: y = {{W{1'b0}}, ~(a ^ b)};
      ALU_GTU:  y = {{(2*W-1){1'b0}}, a > b};
      ALU_EQ:   y = {{(2*W-1){1'b0}}, a == b};
      ALU_MULS: y = prod_s;
      ALU_SRA:  y = {{W{1'b0}}, sra_v};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational core followed
// by a registered double-width result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         ALU_Select,
  output logic [2*WIDTH-1:0] ALU_Out
);

  logic [2*WIDTH-1:0] core_y;

  alu_core #(
    .W (WIDTH)
  ) u_core (
    .a  (A),
    .b  (B),
    .op (ALU_Select),
    .y  (core_y)
  );

  // Result register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ALU_Out <= '0;
    else        ALU_Out <= core_y;
  end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed checks of alu against
// an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sel;
  logic [63:0] out;

  int checks;
  int errors;

  alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a),
    .B          (b),
    .ALU_Select (sel),
    .ALU_Out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint unsigned ux, uy, m;
    longint sx, sy;
    int s;
    ux = 64'(x);
    uy = 64'(y);
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    s  = int'(y % 32);
    m  = 64'hFFFF_FFFF;
    case (op)
      5'h01: return ux + uy;
      5'h02: return (ux - uy) & 64'h1_FFFF_FFFF;
      5'h03: return ux * uy;
      5'h04: return (uy == 0) ? m : ux / uy;
      5'h05: return (uy == 0) ? ux : ux % uy;
      5'h06: return (ux << s) & m;
      5'h07: return ux >> s;
      5'h08: return ((ux << s) | (ux >> (32 - s))) & m;
      5'h09: return ((ux >> s) | (ux << (32 - s))) & m;
      5'h0A: return ux & uy;
      5'h0B: return ux | uy;
      5'h0C: return ux ^ uy;
      5'h0D: return ~(ux | uy) & m;
      5'h0E: return ~(ux & uy) & m;
      5'h0F: return ~(ux ^ uy) & m;
      5'h10: return (ux > uy) ? 64'd1 : 64'd0;
      5'h11: return (ux == uy) ? 64'd1 : 64'd0;
      5'h12: return sx * sy;
      5'h13: return longint'(sx >>> s) & m;
      default: return 64'd0;
    endcase
  endfunction

  // Drive one op just after an edge; check it one edge later
  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp);
    sel = op;
    a   = x;
    b   = y;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  task automatic run_ref(input string tag, input logic [4:0] op,
                         input logic [31:0] x, input logic [31:0] y);
    run(tag, op, x, y, ref_alu(op, x, y));
  endtask

  logic [63:0] sweep_exp [17];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a = '0;
    b = '0;
    sel = '0;
    #1;
    chk("reset_init", out, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", out, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sweep_exp = '{64'hC, 64'h8, 64'h14, 64'h5, 64'h0, 64'h28,
                  64'h2, 64'h28, 64'h8000_0002, 64'h2, 64'hA,
                  64'h8, 64'hFFFF_FFF5, 64'hFFFF_FFFD,
                  64'hFFFF_FFF7, 64'h1, 64'h0};
    for (int i = 0; i < 17; i++) begin
      run($sformatf("sweep_op%0h", i + 1), 5'(i + 1),
          32'h0A, 32'h02, sweep_exp[i]);
    end

    run("sub_f6", 5'h02, 32'hF6, 32'h0A, 64'hEC);
    run("mulu_f6", 5'h03, 32'hF6, 32'h0A, 64'h99C);
    run("divu_f6", 5'h04, 32'hF6, 32'h0A, 64'h18);
    run("modu_f6", 5'h05, 32'hF6, 32'h0A, 64'h6);
    run("gtu_f6", 5'h10, 32'hF6, 32'h0A, 64'h1);

    run("add_carry", 5'h01, 32'hFFFF_FFFF, 32'h1,
        64'h1_0000_0000);
    run("sub_borrow", 5'h02, 32'h2, 32'hA, 64'h1_FFFF_FFF8);
    run("mulu_max", 5'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001);
    run("muls_neg", 5'h12, 32'hFFFF_FFFF, 32'h2,
        64'hFFFF_FFFF_FFFF_FFFE);
    run("divu_zero", 5'h04, 32'h1234, 32'h0, 64'hFFFF_FFFF);
    run("modu_zero", 5'h05, 32'h1234, 32'h0, 64'h1234);
    run("sra_neg", 5'h13, 32'h8000_0000, 32'h4, 64'hF800_0000);
    run("op_1f", 5'h1F, 32'h1234, 32'h5678, 64'h0);
    run("rol_zero", 5'h08, 32'hDEAD_BEEF, 32'h20,
        64'hDEAD_BEEF);
    run("shl_hi_ign", 5'h06, 32'h1, 32'hFFFF_FFE3, 64'h8);
    run("eq_true", 5'h11, 32'h5555, 32'h5555, 64'h1);

    // Mid-run reset clears output without a clock edge
    sel = 5'h01;
    a = 32'h10;
    b = 32'h20;
    @(posedge clk);
    #1;
    chk("pre_reset", out, 64'h30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", out, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_held", out, 64'h0);
    @(negedge clk);
    sel = 5'h03;
    a = 32'h7;
    b = 32'h6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", out, 64'h2A);

    // Back-to-back random ops, new opcode every cycle
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x, y;
      logic [4:0]  op;
      op = 5'($urandom_range(0, 31));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: y = 32'(y[4:0]);
        2: x = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_ref($sformatf("rand%0d_op%0h", i, op), op, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
